// File: rtl/jtag_tx_sched.sv
// jtag_tx_sched: round-robin scheduler and hex/CR/LF formatter for the
// JTAG UART transmit channel. Each granted request word is sent MS-digit
// first as uppercase ASCII hex, then CR LF, over a valid/ready byte handshake.
module jtag_tx_sched #(
  parameter int NREQ   = 3,
  parameter int WORD_W = 36
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] req_word,
  input  logic [NREQ*4-1:0]      req_nibbles,
  output logic [NREQ-1:0]        ack,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy
);

  localparam int            GW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            MAX_NIB   = WORD_W / 4;
  localparam logic [GW-1:0] LAST_IDX  = GW'(NREQ - 1);
  localparam logic [3:0]    MAX_NIB_L = 4'(MAX_NIB);

  typedef enum logic [1:0] {
    IDLE,
    HEX,
    CR,
    LF
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;

  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     grant_idx;
  logic              grant_valid;
  logic [WORD_W-1:0] sel_word;
  logic [3:0]        sel_nib;
  logic [3:0]        load_nib;
  logic              xfer;

  // Nibble to uppercase ASCII hex; the 8-bit sum cannot overflow.
  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    if (d < 4'd10) begin
      return {4'h0, d} + 8'd48;
    end
    return {4'h0, d} + 8'd55;
  endfunction

  // Round-robin search: first set req bit starting one past the last grant.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_ptr      = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      rr_ptr = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
      if (!grant_valid && req[rr_ptr]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr;
      end
    end
  end

  // Pick the granted source's word and clamp its digit count.
  always_comb begin
    sel_word = req_word[int'(grant_idx)*WORD_W +: WORD_W];
    sel_nib  = req_nibbles[int'(grant_idx)*4 +: 4];
    load_nib = (sel_nib > MAX_NIB_L) ? MAX_NIB_L : sel_nib;
  end

  // Output decode: valid whenever a message is in flight, byte from state.
  always_comb begin
    tx_valid = (state_q != IDLE);
    busy     = tx_valid;
    ack      = ack_q;
    tx_data  = 8'h00;
    case (state_q)
      HEX:     tx_data = hex_ascii(shreg_q[WORD_W-1 -: 4]);
      CR:      tx_data = 8'h0D;
      LF:      tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

  assign xfer = tx_valid && tx_ready;

  // Next-state logic: grant in IDLE, then advance one byte per transfer.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          ack_d[grant_idx] = 1'b1;
          last_grant_d     = grant_idx;
          // Left-justify so the current digit is always the top nibble.
          shreg_d          = sel_word << (WORD_W - 4*int'(load_nib));
          cnt_d            = load_nib;
          state_d          = (load_nib != 4'd0) ? HEX : CR;
        end
      end
      HEX: begin
        if (xfer) begin
          shreg_d = shreg_q << 4;
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = CR;
          end
        end
      end
      CR: begin
        if (xfer) begin
          state_d = LF;
        end
      end
      LF: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // blocking ones here would make results depend on statement order.
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= LAST_IDX;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
    end
  end

endmodule

// File: tb/tb_jtag_tx_sched.sv
// Self-checking bench for jtag_tx_sched: table of single-source messages,
// plus round-robin, stall, reset-abort and late-request sequences. A negedge
// monitor predicts grants with its own round-robin model and scoreboards
// every transferred byte against the expected message queue.
module tb_jtag_tx_sched;

  localparam int NREQ   = 3;
  localparam int WORD_W = 36;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WORD_W-1:0] req_word = '0;
  logic [NREQ*4-1:0]      req_nibbles = '0;
  logic                   tx_ready = 1'b1;
  logic [NREQ-1:0]        ack;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   busy;

  int n_vec = 0;
  int n_err = 0;
  bit stall_mode = 1'b0;

  logic [7:0] byte_q[$];
  logic [7:0] exp_msg[NREQ][$];
  int         ack_log[$];
  int         model_last = NREQ - 1;

  logic [NREQ-1:0] req_prev = '0;
  bit              stall_prev = 1'b0;
  logic [7:0]      data_prev = 8'h00;
  int              mon_g;
  logic [NREQ-1:0] mon_exp;

  typedef struct {
    int          src;
    logic [35:0] word;
    logic [3:0]  nib;
    bit          stall;
    string       digits;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  jtag_tx_sched #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_word    (req_word),
    .req_nibbles (req_nibbles),
    .ack         (ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Load a source with a table-supplied expected digit string.
  task automatic set_src_str(input int s, input logic [35:0] w, input logic [3:0] nib,
                             input string digits);
    req_word[s*WORD_W +: WORD_W] = w;
    req_nibbles[s*4 +: 4] = nib;
    exp_msg[s].delete();
    for (int k = 0; k < digits.len(); k++) exp_msg[s].push_back(digits[k]);
    exp_msg[s].push_back(8'h0D);
    exp_msg[s].push_back(8'h0A);
  endtask

  // Load a source and derive the expected text from a hex formatting model.
  task automatic set_src_model(input int s, input logic [35:0] w, input logic [3:0] nib);
    int n;
    logic [3:0] d;
    req_word[s*WORD_W +: WORD_W] = w;
    req_nibbles[s*4 +: 4] = nib;
    n = (int'(nib) > WORD_W / 4) ? WORD_W / 4 : int'(nib);
    exp_msg[s].delete();
    for (int i = n - 1; i >= 0; i--) begin
      d = w[i*4 +: 4];
      exp_msg[s].push_back((d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h41 + {4'h0, d} - 8'd10);
    end
    exp_msg[s].push_back(8'h0D);
    exp_msg[s].push_back(8'h0A);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    step();
    while (ack == '0 && lat < 40) begin
      lat++;
      step();
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 400) begin
      step();
      c++;
    end
    check("msg_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Ready driver: random stalls when enabled, otherwise always ready.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: grant prediction, byte scoreboard and stall stability.
  always @(negedge clock) begin
    if (ack != '0) begin
      mon_g = rr_pick(model_last, req_prev);
      mon_exp = '0;
      if (mon_g >= 0) mon_exp[mon_g] = 1'b1;
      check("ack_grant", 64'(ack), 64'(mon_exp));
      check("one_ack_per_msg", 64'(byte_q.size()), 64'd0);
      if (mon_g >= 0) begin
        model_last = mon_g;
        ack_log.push_back(mon_g);
        for (int k = 0; k < exp_msg[mon_g].size(); k++) byte_q.push_back(exp_msg[mon_g][k]);
      end
    end
    if (stall_prev) check("stall_hold", 64'({tx_valid, tx_data}), 64'({1'b1, data_prev}));
    if (reset) begin
      model_last = NREQ - 1;
      byte_q.delete();
    end else if (tx_valid && tx_ready) begin
      if (byte_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_byte: got %0h expected no byte at %0t", tx_data, $time);
      end else begin
        check("tx_byte", 64'(tx_data), 64'(byte_q.pop_front()));
      end
    end
    stall_prev = tx_valid && !tx_ready && !reset;
    data_prev  = tx_data;
    req_prev   = req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    int c;

    vecs[0] = '{0, 36'h000000ABC, 4'd3,  1'b0, "ABC"};
    vecs[1] = '{1, 36'h123456789, 4'd15, 1'b0, "123456789"};
    vecs[2] = '{2, 36'hFEDCBA987, 4'd0,  1'b0, ""};
    vecs[3] = '{0, 36'h00000F0A5, 4'd4,  1'b1, "F0A5"};
    vecs[4] = '{1, 36'h00000000F, 4'd1,  1'b0, "F"};
    vecs[5] = '{2, 36'h9ABCDEF01, 4'd9,  1'b1, "9ABCDEF01"};
    vecs[6] = '{0, 36'h000000030, 4'd2,  1'b0, "30"};
    vecs[7] = '{1, 36'h123456789, 4'd10, 1'b1, "123456789"};

    // Reset values.
    reset = 1'b1;
    repeat (3) step();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_data", 64'(tx_data), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    step();

    // Table of single-source messages.
    for (int i = 0; i < 8; i++) begin
      stall_mode = vecs[i].stall;
      set_src_str(vecs[i].src, vecs[i].word, vecs[i].nib, vecs[i].digits);
      req = '0;
      req[vecs[i].src] = 1'b1;
      wait_ack(lat);
      check("ack_latency", 64'(lat), 64'd0);
      check("busy_with_valid", 64'({busy, tx_valid}), 64'd3);
      req = '0;
      wait_idle();
      check("bytes_drained", 64'(byte_q.size()), 64'd0);
      stall_mode = 1'b0;
      step();
    end

    // Round-robin with all requests held high.
    do_reset();
    ack_log.delete();
    set_src_model(0, 36'h000000111, 4'd3);
    set_src_model(1, 36'h0000ABCDE, 4'd5);
    set_src_model(2, 36'h000000007, 4'd1);
    req = 3'b111;
    cnt = 0;
    c = 0;
    while (cnt < 6 && c < 400) begin
      step();
      c++;
      if (ack != '0) cnt++;
    end
    req = '0;
    wait_idle();
    check("rr_ack_count", 64'(ack_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) check("rr_order", 64'(ack_log[i]), 64'(i % 3));
    step();

    // Reset after the second digit of a 5-digit message.
    set_src_str(0, 36'h000012345, 4'd5, "12345");
    req = 3'b001;
    wait_ack(lat);
    check("abort_ack_latency", 64'(lat), 64'd0);
    req = '0;
    step();
    step();
    check("pre_reset_digit", 64'(tx_data), 64'h33);
    reset = 1'b1;
    step();
    check("abort_valid", {63'd0, tx_valid}, 64'd0);
    check("abort_data", 64'(tx_data), 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_ack", 64'(ack), 64'd0);
    reset = 1'b0;

    // Priority after reset starts again at source 0.
    set_src_model(0, 36'h000000ACE, 4'd3);
    set_src_model(1, 36'h000000BD0, 4'd3);
    set_src_model(2, 36'h000000F00, 4'd3);
    req = 3'b111;
    wait_ack(lat);
    check("post_reset_grant", 64'(ack), 64'd1);
    req = '0;
    wait_idle();
    step();

    // Source 2 requests while source 0 is in flight.
    set_src_str(0, 36'h000000ABC, 4'd3, "ABC");
    set_src_str(2, 36'h00000005A, 4'd2, "5A");
    req = 3'b001;
    wait_ack(lat);
    check("first_ack", 64'(ack), 64'd1);
    req = 3'b100;
    c = 0;
    do begin
      step();
      c++;
    end while (!ack[2] && c < 40);
    check("late_req_gap", 64'(c), 64'd6);
    check("late_ack", 64'(ack), 64'd4);
    req = '0;
    wait_idle();
    check("final_drain", 64'(byte_q.size()), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
